// File: rtl/ps2_pkg.sv
// Shared scan-code constants, key bit positions and receiver state for the PS/2 arrow-key block.
// Optional build macro: PS2_WASD_EN also maps the W/S/D/A letter keys onto the arrow bits.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_A     = 8'h1C;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_LEFT  = 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } key_hit_t;

    // Arrow codes only count after an E0 prefix; letter codes only without one.
    function automatic key_hit_t lookupKey(input logic [7:0] code, input logic ext);
        key_hit_t r;
        r.hit = 1'b0;
        r.idx = 2'd0;
        if (ext) begin
            case (code)
                SC_UP:    begin r.hit = 1'b1; r.idx = 2'(KEY_UP);    end
                SC_DOWN:  begin r.hit = 1'b1; r.idx = 2'(KEY_DOWN);  end
                SC_RIGHT: begin r.hit = 1'b1; r.idx = 2'(KEY_RIGHT); end
                SC_LEFT:  begin r.hit = 1'b1; r.idx = 2'(KEY_LEFT);  end
                default:  ;
            endcase
        end
`ifdef PS2_WASD_EN
        else begin
            case (code)
                SC_W:    begin r.hit = 1'b1; r.idx = 2'(KEY_UP);    end
                SC_S:    begin r.hit = 1'b1; r.idx = 2'(KEY_DOWN);  end
                SC_D:    begin r.hit = 1'b1; r.idx = 2'(KEY_RIGHT); end
                SC_A:    begin r.hit = 1'b1; r.idx = 2'(KEY_LEFT);  end
                default: ;
            endcase
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/ps2_arrow_keys_if.sv
// Pin and result bundle of the PS/2 arrow-key block; master is the keyboard side, slave the block.
interface ps2_arrow_keys_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] keyboard_keys;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_error;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keyboard_keys,
        input  rx_byte,
        input  rx_valid,
        input  frame_error
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keyboard_keys,
        output rx_byte,
        output rx_valid,
        output frame_error
    );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame FSM and a stall watchdog.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       frame_error_o
);

    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [SYNC_STAGES-1:0] dataSync_q;
    logic                   clkPrev_q;
    logic                   fallEdge;
    logic                   dataBit;

    rx_state_e   state_q;
    logic [2:0]  bitCnt_q;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic [7:0]  rxByte_q;
    logic        rxValid_q;
    logic        frameErr_q;
    logic [WDOG_W-1:0] wdog_q;

    // Synchronizers reset low so a released, idle-high clock line never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkSync_q  <= '0;
            dataSync_q <= '0;
            clkPrev_q  <= 1'b0;
        end else begin
            clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], ps2_data_i};
            clkPrev_q  <= clkSync_q[SYNC_STAGES-1];
        end
    end

    assign fallEdge = clkPrev_q & ~clkSync_q[SYNC_STAGES-1];
    assign dataBit  = dataSync_q[SYNC_STAGES-1];

    // The watchdog is loaded with 1 on the edge so the timeout pulse lands TIMEOUT_CYCLES after that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            rxByte_q   <= '0;
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            wdog_q     <= '0;
        end else begin
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            if (state_q != RX_IDLE && !fallEdge && wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                state_q    <= RX_IDLE;
                frameErr_q <= 1'b1;
                wdog_q     <= '0;
            end else if (fallEdge) begin
                wdog_q <= WDOG_W'(1);
                case (state_q)
                    RX_IDLE: begin
                        bitCnt_q <= '0;
                        if (!dataBit) begin
                            state_q <= RX_DATA;
                        end else begin
                            wdog_q <= '0;
                        end
                    end
                    RX_DATA: begin
                        shift_q  <= {dataBit, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        parity_q <= dataBit;
                        state_q  <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (dataBit && (^{shift_q, parity_q})) begin
                            rxByte_q  <= shift_q;
                            rxValid_q <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                        state_q <= RX_IDLE;
                        wdog_q  <= '0;
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end else if (state_q != RX_IDLE) begin
                wdog_q <= wdog_q + WDOG_W'(1);
            end
        end
    end

    assign rx_byte_o     = rxByte_q;
    assign rx_valid_o    = rxValid_q;
    assign frame_error_o = frameErr_q;

endmodule

// File: rtl/ps2_arrow_keys.sv
// PS/2 arrow-key front end: receives scan-code set 2 bytes and keeps a held-key vector [left,right,down,up].
// Optional build macro: PS2_WASD_EN (see ps2_pkg::lookupKey).
module ps2_arrow_keys
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic          clk,
    input logic          rst_n,
    ps2_arrow_keys_if.slave bus
);

    logic [7:0] rxByte;
    logic       rxValid;
    logic       frameErr;
    key_hit_t   keyHit;

    logic       e0Seen_q, e0Seen_d;
    logic       f0Seen_q, f0Seen_d;
    logic [3:0] keys_q,   keys_d;

    ps2_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk_i    (bus.ps2_clk),
        .ps2_data_i   (bus.ps2_data),
        .rx_byte_o    (rxByte),
        .rx_valid_o   (rxValid),
        .frame_error_o(frameErr)
    );

    assign keyHit = lookupKey(rxByte, e0Seen_q);

    // Prefix bytes only arm flags; the next non-prefix byte consumes them whether or not it maps to a key.
    always_comb begin
        e0Seen_d = e0Seen_q;
        f0Seen_d = f0Seen_q;
        keys_d   = keys_q;
        if (frameErr) begin
            e0Seen_d = 1'b0;
            f0Seen_d = 1'b0;
        end else if (rxValid) begin
            if (rxByte == SC_EXT) begin
                e0Seen_d = 1'b1;
            end else if (rxByte == SC_BREAK) begin
                f0Seen_d = 1'b1;
            end else begin
                if (keyHit.hit) begin
                    keys_d[keyHit.idx] = ~f0Seen_q;
                end
                e0Seen_d = 1'b0;
                f0Seen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0Seen_q <= 1'b0;
            f0Seen_q <= 1'b0;
            keys_q   <= '0;
        end else begin
            e0Seen_q <= e0Seen_d;
            f0Seen_q <= f0Seen_d;
            keys_q   <= keys_d;
        end
    end

    assign bus.keyboard_keys = keys_q;
    assign bus.rx_byte       = rxByte;
    assign bus.rx_valid      = rxValid;
    assign bus.frame_error   = frameErr;

endmodule

// File: tb/tb_ps2_arrow_keys.sv
// Scoreboard bench for ps2_arrow_keys: drives PS/2 frames, predicts each rx_valid/frame_error and key vector.
module tb_ps2_arrow_keys;

    localparam int SYNC = 2;
    localparam int TOUT = 400;
    localparam int H    = 15;

    logic clk;
    logic rst_n;

    ps2_arrow_keys_if ps2Bus ();

    ps2_arrow_keys #(
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ps2Bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         isErr;
        logic [7:0] rxByte;
        logic [3:0] keysBefore;
        logic [3:0] keysAfter;
    } exp_t;

    exp_t sbQ[$];

    int checkCount = 0;
    int passCount  = 0;

    logic [3:0] mKeys = '0;
    logic [7:0] mLast = '0;
    bit         mE0   = 1'b0;
    bit         mF0   = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    function automatic bit tbKeyOf(input logic [7:0] b, input bit ext, output int idx);
        idx = 0;
        if (ext) begin
            case (b)
                8'h75: begin idx = 0; return 1'b1; end
                8'h72: begin idx = 1; return 1'b1; end
                8'h74: begin idx = 2; return 1'b1; end
                8'h6B: begin idx = 3; return 1'b1; end
                default: return 1'b0;
            endcase
        end
`ifdef PS2_WASD_EN
        case (b)
            8'h1D: begin idx = 0; return 1'b1; end
            8'h1B: begin idx = 1; return 1'b1; end
            8'h23: begin idx = 2; return 1'b1; end
            8'h1C: begin idx = 3; return 1'b1; end
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelByte(input logic [7:0] b, input bit bad);
        exp_t e;
        int   idx;
        e.keysBefore = mKeys;
        if (bad) begin
            e.isErr  = 1'b1;
            e.rxByte = mLast;
            mE0 = 1'b0;
            mF0 = 1'b0;
        end else begin
            e.isErr  = 1'b0;
            e.rxByte = b;
            mLast    = b;
            if (b == 8'hE0) begin
                mE0 = 1'b1;
            end else if (b == 8'hF0) begin
                mF0 = 1'b1;
            end else begin
                if (tbKeyOf(b, mE0, idx)) mKeys[idx] = ~mF0;
                mE0 = 1'b0;
                mF0 = 1'b0;
            end
        end
        e.keysAfter = mKeys;
        sbQ.push_back(e);
    endtask

    task automatic ps2Edge(input logic d);
        @(negedge clk) ps2Bus.ps2_data = d;
        repeat (H) @(negedge clk);
        ps2Bus.ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2Bus.ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad);
        logic [10:0] frame;
        logic        par;
        par   = bad ? (^b) : ~(^b);
        frame = {1'b1, par, b, 1'b0};
        modelByte(b, bad);
        for (int i = 0; i < 11; i++) ps2Edge(frame[i]);
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 3000 && sbQ.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("sb_drain", sbQ.size(), 0);
    endtask

    // Monitor: every output pulse must match the next scoreboard entry; keys move exactly one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (ps2Bus.rx_valid && ps2Bus.frame_error) checkOutput("pulse_exclusive", 1, 0);
            if (ps2Bus.rx_valid || ps2Bus.frame_error) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_pulse", {ps2Bus.frame_error, ps2Bus.rx_byte}, 0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("pulse_kind", ps2Bus.frame_error, e.isErr);
                    checkOutput("rx_byte", ps2Bus.rx_byte, e.rxByte);
                    checkOutput("keys_hold", ps2Bus.keyboard_keys, e.keysBefore);
                    @(negedge clk);
                    checkOutput("keys_after", ps2Bus.keyboard_keys, e.keysAfter);
                end
            end
        end
    end

    initial begin
        int latency;
        rst_n = 1'b0;
        ps2Bus.ps2_clk  = 1'b1;
        ps2Bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_keys", ps2Bus.keyboard_keys, 0);
        checkOutput("rst_rx_byte", ps2Bus.rx_byte, 0);
        checkOutput("rst_pulses", {ps2Bus.rx_valid, ps2Bus.frame_error}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] single up make/break");
        applyStimulus(8'hE0, 0); applyStimulus(8'h75, 0); waitDrain();
        checkOutput("up_make", ps2Bus.keyboard_keys, 4'b0001);
        applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h75, 0); waitDrain();
        checkOutput("up_break", ps2Bus.keyboard_keys, 4'b0000);

        $display("[TB] two keys held");
        applyStimulus(8'hE0, 0); applyStimulus(8'h6B, 0);
        applyStimulus(8'hE0, 0); applyStimulus(8'h74, 0); waitDrain();
        checkOutput("left_right", ps2Bus.keyboard_keys, 4'b1100);
        applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h6B, 0); waitDrain();
        checkOutput("left_break", ps2Bus.keyboard_keys, 4'b0100);
        applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h74, 0); waitDrain();

        $display("[TB] unmapped bytes and parity error");
        applyStimulus(8'hE0, 0); applyStimulus(8'h75, 0);
        applyStimulus(8'hAA, 0); applyStimulus(8'hFA, 0);
        applyStimulus(8'hE0, 0); applyStimulus(8'h12, 0); waitDrain();
        checkOutput("unmapped_hold", ps2Bus.keyboard_keys, 4'b0001);
        applyStimulus(8'h75, 1); waitDrain();
        applyStimulus(8'hE0, 0); applyStimulus(8'h75, 1); applyStimulus(8'h75, 0); waitDrain();
        checkOutput("err_clears_e0", ps2Bus.keyboard_keys, 4'b0001);
        applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h75, 0); waitDrain();
        checkOutput("break_after_err", ps2Bus.keyboard_keys, 4'b0000);

        $display("[TB] watchdog timeout");
        modelByte(8'h00, 1);
        ps2Edge(0); ps2Edge(1); ps2Edge(0); ps2Edge(1);
        @(negedge clk) ps2Bus.ps2_data = 1'b0;
        repeat (H) @(negedge clk);
        ps2Bus.ps2_clk = 1'b0;
        latency = 0;
        for (int n = 1; n <= SYNC + TOUT + 50; n++) begin
            @(posedge clk);
            #1;
            if (n == H) ps2Bus.ps2_clk = 1'b1;
            if (ps2Bus.frame_error) begin
                latency = n;
                break;
            end
        end
        checkOutput("timeout_latency", latency, SYNC + TOUT);
        repeat (2 * H) @(negedge clk);
        waitDrain();
        applyStimulus(8'hE0, 0); applyStimulus(8'h72, 0); waitDrain();
        checkOutput("down_after_timeout", ps2Bus.keyboard_keys, 4'b0010);
        applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h72, 0); waitDrain();

        $display("[TB] letter code W");
        applyStimulus(8'h1D, 0); waitDrain();
`ifdef PS2_WASD_EN
        checkOutput("w_make", ps2Bus.keyboard_keys, 4'b0001);
`else
        checkOutput("w_make", ps2Bus.keyboard_keys, 4'b0000);
`endif
        applyStimulus(8'hF0, 0); applyStimulus(8'h1D, 0); waitDrain();
        checkOutput("w_break", ps2Bus.keyboard_keys, 4'b0000);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hE0, 0); applyStimulus(8'h75, 0); waitDrain();
        ps2Edge(0); ps2Edge(1); ps2Edge(0); ps2Edge(1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        checkOutput("midrst_keys", ps2Bus.keyboard_keys, 0);
        checkOutput("midrst_rx_byte", ps2Bus.rx_byte, 0);
        checkOutput("midrst_pulses", {ps2Bus.rx_valid, ps2Bus.frame_error}, 0);
        mKeys = '0; mLast = '0; mE0 = 1'b0; mF0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ps2Edge(1);
        repeat (2 * H) @(negedge clk);
        applyStimulus(8'hE0, 0); applyStimulus(8'h72, 0); waitDrain();
        checkOutput("down_after_reset", ps2Bus.keyboard_keys, 4'b0010);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
